// File: rtl/exp_job_arbiter_if.sv
// Requester/engine bundle for the exponent-job arbiter.
// Latency: none (wires only).
// Backpressure: requesters hold req_valid until req_ready; responses hold until resp_ack.
//
// Signals:
//   req_valid/req_a/req_n  per-requester request and operands (slot i at [i*W +: W])
//   req_ready              one-cycle accept pulse per requester
//   resp_valid/resp_result/resp_err/resp_ack  per-requester response handshake, shared result bus
//   eng_go/eng_a/eng_n/eng_result/eng_done    exponent engine connection
//   busy                   arbiter not idle
interface exp_job_arbiter_if #(
    parameter int NREQ = 4,
    parameter int W    = 8,
    parameter int RW   = 16
);
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_n;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ-1:0]   resp_valid;
    logic [RW-1:0]     resp_result;
    logic              resp_err;
    logic [NREQ-1:0]   resp_ack;
    logic              eng_go;
    logic [W-1:0]      eng_a;
    logic [W-1:0]      eng_n;
    logic [RW-1:0]     eng_result;
    logic              eng_done;
    logic              busy;

    // Arbiter side
    modport slave (
        input  req_valid, req_a, req_n, resp_ack, eng_result, eng_done,
        output req_ready, resp_valid, resp_result, resp_err, eng_go, eng_a, eng_n, busy
    );

    // Requester/engine environment side
    modport master (
        output req_valid, req_a, req_n, resp_ack, eng_result, eng_done,
        input  req_ready, resp_valid, resp_result, resp_err, eng_go, eng_a, eng_n, busy
    );
endinterface

// File: rtl/exp_job_arbiter.sv
// Round-robin arbiter sharing one a^n engine between NREQ requesters, with job watchdog.
// Latency: req_ready 1 cycle after request seen in IDLE; resp_valid 1 cycle after eng_done rises.
// Backpressure: one job at a time; response held until the owner's resp_ack, no new job meanwhile.
//
// Ports:
//   clk     system clock, rising edge
//   rst     synchronous reset, active-low
//   io_job  requester + engine bundle (exp_job_arbiter_if.slave), all outputs registered
module exp_job_arbiter #(
    parameter int NREQ      = 4,
    parameter int W         = 8,
    parameter int RW        = 16,
    parameter int TO_CYCLES = 1023
) (
    input  logic             clk,
    input  logic             rst,
    exp_job_arbiter_if.slave io_job
);
    localparam int PW  = $clog2(NREQ);
    localparam int SW  = PW + 1;
    localparam int WDW = $clog2(TO_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_LOW, WAIT_HI, RESP} state_t;

    state_t          r_state,       w_state_nxt;
    logic [PW-1:0]   r_ptr,         w_ptr_nxt;     // last grant; also owner of the current job
    logic [WDW-1:0]  r_wdog,        w_wdog_nxt;
    logic [NREQ-1:0] r_req_ready,   w_req_ready_nxt;
    logic [NREQ-1:0] r_resp_valid,  w_resp_valid_nxt;
    logic [RW-1:0]   r_resp_result, w_resp_result_nxt;
    logic            r_resp_err,    w_resp_err_nxt;
    logic            r_eng_go,      w_eng_go_nxt;
    logic [W-1:0]    r_eng_a,       w_eng_a_nxt;
    logic [W-1:0]    r_eng_n,       w_eng_n_nxt;
    logic            r_busy,        w_busy_nxt;

    logic            w_found;
    logic [PW-1:0]   w_gnt;
    logic [SW-1:0]   w_idx;
    logic            w_timeout;

    // First valid requester after the pointer, wrapping modulo NREQ.
    always_comb begin
        w_found = 1'b0;
        w_gnt   = r_ptr;
        w_idx   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            w_idx = {1'b0, r_ptr} + SW'(k);
            if (w_idx >= SW'(NREQ)) begin
                w_idx = w_idx - SW'(NREQ);
            end
            if (!w_found && io_job.req_valid[w_idx[PW-1:0]]) begin
                w_found = 1'b1;
                w_gnt   = w_idx[PW-1:0];
            end
        end
    end

    // Counter holds cycles already spent waiting; this is the TO_CYCLES-th one.
    assign w_timeout = (r_wdog == WDW'(TO_CYCLES - 1));

    always_comb begin
        w_state_nxt       = r_state;
        w_ptr_nxt         = r_ptr;
        w_wdog_nxt        = r_wdog;
        w_req_ready_nxt   = '0;
        w_resp_valid_nxt  = r_resp_valid;
        w_resp_result_nxt = r_resp_result;
        w_resp_err_nxt    = r_resp_err;
        w_eng_go_nxt      = 1'b0;
        w_eng_a_nxt       = r_eng_a;
        w_eng_n_nxt       = r_eng_n;

        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_ptr_nxt              = w_gnt;
                    w_eng_a_nxt            = io_job.req_a[w_gnt*W +: W];
                    w_eng_n_nxt            = io_job.req_n[w_gnt*W +: W];
                    w_req_ready_nxt[w_gnt] = 1'b1;
                    w_eng_go_nxt           = 1'b1;
                    w_state_nxt            = ISSUE;
                end
            end
            ISSUE: begin
                w_wdog_nxt  = '0;
                w_state_nxt = WAIT_LOW;
            end
            // The engine may still show done from its previous job; wait for it to drop first.
            WAIT_LOW: begin
                w_wdog_nxt = r_wdog + WDW'(1);
                if (w_timeout) begin
                    w_resp_result_nxt       = '0;
                    w_resp_err_nxt          = 1'b1;
                    w_resp_valid_nxt        = '0;
                    w_resp_valid_nxt[r_ptr] = 1'b1;
                    w_state_nxt             = RESP;
                end else if (!io_job.eng_done) begin
                    w_state_nxt = WAIT_HI;
                end
            end
            // A real result arriving on the last allowed cycle wins over the timeout.
            WAIT_HI: begin
                w_wdog_nxt = r_wdog + WDW'(1);
                if (io_job.eng_done || w_timeout) begin
                    w_resp_result_nxt       = io_job.eng_done ? io_job.eng_result : '0;
                    w_resp_err_nxt          = !io_job.eng_done;
                    w_resp_valid_nxt        = '0;
                    w_resp_valid_nxt[r_ptr] = 1'b1;
                    w_state_nxt             = RESP;
                end
            end
            RESP: begin
                if (io_job.resp_ack[r_ptr]) begin
                    w_resp_valid_nxt = '0;
                    w_state_nxt      = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        w_busy_nxt = (w_state_nxt != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state       <= IDLE;
            r_ptr         <= PW'(NREQ - 1);
            r_wdog        <= '0;
            r_req_ready   <= '0;
            r_resp_valid  <= '0;
            r_resp_result <= '0;
            r_resp_err    <= 1'b0;
            r_eng_go      <= 1'b0;
            r_eng_a       <= '0;
            r_eng_n       <= '0;
            r_busy        <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_ptr         <= w_ptr_nxt;
            r_wdog        <= w_wdog_nxt;
            r_req_ready   <= w_req_ready_nxt;
            r_resp_valid  <= w_resp_valid_nxt;
            r_resp_result <= w_resp_result_nxt;
            r_resp_err    <= w_resp_err_nxt;
            r_eng_go      <= w_eng_go_nxt;
            r_eng_a       <= w_eng_a_nxt;
            r_eng_n       <= w_eng_n_nxt;
            r_busy        <= w_busy_nxt;
        end
    end

    assign io_job.req_ready   = r_req_ready;
    assign io_job.resp_valid  = r_resp_valid;
    assign io_job.resp_result = r_resp_result;
    assign io_job.resp_err    = r_resp_err;
    assign io_job.eng_go      = r_eng_go;
    assign io_job.eng_a       = r_eng_a;
    assign io_job.eng_n       = r_eng_n;
    assign io_job.busy        = r_busy;
endmodule
